// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the system-ID boot checker: FSM encoding,
// Avalon word offsets and default build-time expected values.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        WT_ID  = 3'd2,
        RD_TS  = 3'd3,
        WT_TS  = 3'd4,
        FINISH = 3'd5
    } state_e;

    localparam logic        ADDR_ID = 1'b0;
    localparam logic        ADDR_TS = 1'b1;

    localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'd1765936223;

    // Wide enough to count one past the largest retry budget (7).
    localparam int unsigned RETRY_W = 4;

    function automatic logic is_read_state(input state_e s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

    function automatic logic is_xfer_state(input state_e s);
        return (s == RD_ID) || (s == WT_ID) || (s == RD_TS) || (s == WT_TS);
    endfunction

endpackage

// File: rtl/sysid_boot_checker_timeout_cnt.sv
// Saturating per-transaction cycle counter: load clears it, enable counts up,
// hit flags that LIMIT has been reached. Never wraps.
module sysid_timeout_cnt #(
    parameter int unsigned LIMIT = 255,
    localparam int unsigned W    = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic hit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words after
// reset or on request, compares them to build-time values and latches status.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    // Handshake: a read is accepted on the cycle avm_read=1 and
    // avm_waitrequest=0; data is consumed only when avm_readdatavalid=1 in an
    // accepting RD_* cycle or in WT_*, and is ignored in every other state.
    state_e               state_q, state_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [RETRY_W-1:0]   retry_next;
    logic                 auto_pend_q, auto_pend_d;
    logic                 avm_read_q, avm_read_d;
    logic                 avm_address_q, avm_address_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 id_ok_q, id_ok_d;
    logic                 ts_ok_q, ts_ok_d;
    logic                 timeout_q, timeout_d;
    logic [31:0]          id_value_q, id_value_d;
    logic [31:0]          ts_value_q, ts_value_d;

    logic                 cnt_load;
    logic                 cnt_hit;
    logic                 word_is_ts;
    logic                 data_here;

    sysid_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cnt_load),
        .enable  (is_xfer_state(state_q)),
        .hit     (cnt_hit)
    );

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        auto_pend_d = 1'b0;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        timeout_d   = timeout_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        cnt_load    = 1'b0;
        retry_next  = retry_q + RETRY_W'(1);
        word_is_ts  = (state_q == RD_TS) || (state_q == WT_TS);
        data_here   = avm_readdatavalid &&
                      ((state_q == WT_ID) || (state_q == WT_TS) ||
                       (is_read_state(state_q) && !avm_waitrequest));

        case (state_q)
            IDLE: begin
                if (start || auto_pend_q) begin
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    retry_d   = '0;
                    cnt_load  = 1'b1;
                    state_d   = RD_ID;
                end
            end
            RD_ID, WT_ID, RD_TS, WT_TS: begin
                // Data beats the timeout when both land on the same cycle.
                if (data_here) begin
                    cnt_load = 1'b1;
                    if (word_is_ts) begin
                        ts_value_d = avm_readdata;
                        ts_ok_d    = (avm_readdata == EXPECTED_TS);
                        state_d    = FINISH;
                    end else begin
                        id_value_d = avm_readdata;
                        id_ok_d    = (avm_readdata == EXPECTED_ID);
                        state_d    = RD_TS;
                    end
                end else if (cnt_hit) begin
                    if (word_is_ts) begin
                        ts_ok_d = 1'b0;
                    end else begin
                        id_ok_d = 1'b0;
                    end
                    retry_d = retry_next;
                    if (retry_next <= RETRY_LIMIT) begin
                        cnt_load = 1'b1;
                        state_d  = RD_ID;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = FINISH;
                    end
                end else if (is_read_state(state_q) && !avm_waitrequest) begin
                    state_d = word_is_ts ? WT_TS : WT_ID;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        avm_read_d    = is_read_state(state_d);
        avm_address_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == FINISH);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            retry_q       <= '0;
            auto_pend_q   <= AUTO_START;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            auto_pend_q   <= auto_pend_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: a configurable Avalon slave model,
// an expected-result queue popped at each done pulse, and a summary line.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1765936223;
    localparam int          W      = 67;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'hdeadbeef;
    logic        avm_readdatavalid = 1'b0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    // Slave configuration and monitor counters.
    int          cfg_wait = 0;
    int          cfg_lat = 0;
    bit          cfg_silent = 1'b0;
    logic [31:0] slv_id = EXP_ID;
    logic [31:0] slv_ts = EXP_TS;
    int          pend_cnt = 0;
    logic        pend_addr = 1'b0;
    int          stall_n = 0;
    bit          was_stalled = 1'b0;
    logic        stall_addr = 1'b0;
    bit          stall_ok = 1'b1;
    int          rd_id_cnt = 0;
    int          rd_ts_cnt = 0;
    int          done_cnt = 0;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp_q[$];

    sysid_boot_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    // Clock / watchdog
    initial forever #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Slave model: reacts on the falling edge to the registered master outputs.
    initial begin
        forever begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'hdeadbeef;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_addr ? slv_ts : slv_id;
                end
            end
            avm_waitrequest = 1'b0;
            if (avm_read === 1'b1) begin
                if (was_stalled && (avm_address !== stall_addr)) stall_ok = 1'b0;
                if (stall_n < cfg_wait) begin
                    avm_waitrequest = 1'b1;
                    stall_n++;
                    was_stalled = 1'b1;
                    stall_addr  = avm_address;
                end else begin
                    stall_n     = 0;
                    was_stalled = 1'b0;
                    if (avm_address) rd_ts_cnt++;
                    else rd_id_cnt++;
                    if (!cfg_silent) begin
                        if (cfg_lat == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = avm_address ? slv_ts : slv_id;
                        end else begin
                            pend_cnt  = cfg_lat;
                            pend_addr = avm_address;
                        end
                    end
                end
            end else begin
                if (was_stalled) stall_ok = 1'b0;
                stall_n     = 0;
                was_stalled = 1'b0;
            end
        end
    end

    // Driver / checker tasks
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic e_id_ok, input logic e_ts_ok, input logic e_to,
                            input logic [31:0] e_id, input logic [31:0] e_ts);
        exp_q.push_back({e_id_ok, e_ts_ok, e_to, e_id, e_ts});
    endtask

    // Model of a sequence the slave answers fully.
    task automatic push_good();
        push_exp(slv_id == EXP_ID, slv_ts == EXP_TS, 1'b0, slv_id, slv_ts);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called one cycle after the start edge; latency counts edges from start.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        logic [W-1:0] e;
        lat = 1;
        while ((done !== 1'b1) && (lat < 200)) begin
            tick();
            lat++;
        end
        start = 1'b0;
        check($sformatf("%s_done_seen", tag), {31'd0, done}, 32'd1);
        if (done === 1'b1) begin
            check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
            check($sformatf("%s_sb_nonempty", tag), {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s_id_ok", tag), {31'd0, id_ok}, {31'd0, e[66]});
                check($sformatf("%s_ts_ok", tag), {31'd0, ts_ok}, {31'd0, e[65]});
                check($sformatf("%s_timeout", tag), {31'd0, timeout}, {31'd0, e[64]});
                check($sformatf("%s_id_value", tag), id_value, e[63:32]);
                check($sformatf("%s_ts_value", tag), ts_value, e[31:0]);
                check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
            end
            tick();
            check($sformatf("%s_done_one_cycle", tag), {31'd0, done}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
        check($sformatf("%s_done", tag), {31'd0, done}, 32'd0);
        check($sformatf("%s_read", tag), {31'd0, avm_read}, 32'd0);
        check($sformatf("%s_addr", tag), {31'd0, avm_address}, 32'd0);
        check($sformatf("%s_flags", tag), {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        check($sformatf("%s_id_value", tag), id_value, 32'd0);
        check($sformatf("%s_ts_value", tag), ts_value, 32'd0);
    endtask

    // Stimulus
    initial begin
        int rid0, rts0, d0, guard;

        // Power-on reset, then the automatic sequence on release.
        reset_n = 1'b0;
        repeat (3) tick();
        check_all_zero("por");
        push_good();
        reset_n = 1'b1;
        tick();
        check("auto_read", {31'd0, avm_read}, 32'd1);
        check("auto_addr", {31'd0, avm_address}, 32'd0);
        wait_done("auto", 3);
        repeat (2) tick();

        // Zero-latency slave, matching words.
        push_good();
        pulse_start();
        check("zl_read_n1", {31'd0, avm_read}, 32'd1);
        wait_done("zero_lat", 3);
        check("zl_idle_busy", {31'd0, busy}, 32'd0);
        check("zl_hold_ts_ok", {31'd0, ts_ok}, 32'd1);

        // Timestamp mismatch.
        slv_ts = 32'h12345678;
        push_good();
        pulse_start();
        wait_done("ts_bad", 3);
        slv_ts = EXP_TS;
        repeat (2) tick();

        // Four stall cycles per read, data two cycles after accept.
        cfg_wait = 4;
        cfg_lat  = 2;
        stall_ok = 1'b1;
        push_good();
        pulse_start();
        wait_done("stall", 15);
        check("stall_stable", {31'd0, stall_ok}, 32'd1);
        cfg_wait = 0;
        cfg_lat  = 0;
        repeat (2) tick();

        // start held high for the whole sequence.
        rid0 = rd_id_cnt;
        rts0 = rd_ts_cnt;
        d0   = done_cnt;
        push_good();
        start = 1'b1;
        tick();
        wait_done("start_held", 3);
        repeat (6) tick();
        check("held_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("held_id_reads", 32'(rd_id_cnt - rid0), 32'd1);
        check("held_ts_reads", 32'(rd_ts_cnt - rts0), 32'd1);

        // Silent slave: three attempts on word 0, then timeout.
        rid0 = rd_id_cnt;
        rts0 = rd_ts_cnt;
        cfg_silent = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1, slv_id, slv_ts);
        pulse_start();
        wait_done("timeout", 28);
        check("to_id_reads", 32'(rd_id_cnt - rid0), 32'd3);
        check("to_ts_reads", 32'(rd_ts_cnt - rts0), 32'd0);
        cfg_silent = 1'b0;
        repeat (2) tick();

        // Data on the same cycle the counter hits its limit; ID mismatch.
        slv_id  = 32'ha5a50001;
        cfg_lat = 8;
        push_good();
        pulse_start();
        wait_done("edge_lat", 19);
        check("edge_timeout_clear", {31'd0, timeout}, 32'd0);
        repeat (2) tick();

        // Reset while waiting on the timestamp, then automatic restart.
        slv_id  = EXP_ID;
        cfg_lat = 3;
        pulse_start();
        guard = 0;
        while (!((avm_read === 1'b1) && (avm_address === 1'b1)) && (guard < 50)) begin
            tick();
            guard++;
        end
        check("rst_reached_rd_ts", {31'd0, guard < 50}, 32'd1);
        tick();
        d0 = done_cnt;
        reset_n           = 1'b0;
        pend_cnt          = 0;
        avm_readdatavalid = 1'b0;
        tick();
        check_all_zero("mid_rst");
        push_good();
        reset_n = 1'b1;
        tick();
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_auto_read", {31'd0, avm_read}, 32'd1);
        check("rst_auto_busy", {31'd0, busy}, 32'd1);
        wait_done("rst_auto", 9);

        repeat (4) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
